// File: rtl/sseg_spi_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sseg_spi_ctrl_if
//  Purpose  : Bundles the application-side value/request signals and the
//             display-side SPI signals of the 7-segment SPI controller.
//  Signals  : dat  - nibble per digit (digit i = dat[4i+3:4i])
//             dp   - decimal point per digit
//             upd  - refresh request (pulse or level)
//             busy - init or refresh in progress
//             done - one-cycle pulse at the end of a refresh
//             sclk - SPI clock, mode 0
//             sdo  - SPI data, MSB first
//             cs_n - chip select, active low
//  Modports : master - application / bench side
//             slave  - controller side
//  Revision : 1.0 - initial release
// ============================================================================
interface sseg_spi_ctrl_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] dat;
    logic [DIGITS-1:0]   dp;
    logic                upd;
    logic                busy;
    logic                done;
    logic                sclk;
    logic                sdo;
    logic                cs_n;

    modport master (
        output dat, dp, upd,
        input  busy, done, sclk, sdo, cs_n
    );

    modport slave (
        input  dat, dp, upd,
        output busy, done, sclk, sdo, cs_n
    );
endinterface
`default_nettype wire

// File: rtl/sseg_spi_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sseg_spi_ctrl
//  Purpose  : SPI controller for a MAX7219-class multi-digit 7-segment
//             display. Sends the power-up register sequence after reset, then
//             writes one 16-bit frame per digit on every refresh request.
//  Ports    : clk  - system clock
//             rst  - synchronous, active-high reset
//             bus  - sseg_spi_ctrl_if.slave (dat, dp, upd in;
//                    busy, done, sclk, sdo, cs_n out)
//  Revision : 1.0 - initial release
// ============================================================================
module sseg_spi_ctrl #(
    parameter int         DIGITS    = 8,
    parameter int         CLK_DIV   = 4,
    parameter int         GAP       = 2,
    parameter logic [3:0] INTENSITY = 4'h8,
    parameter bit         DECODE    = 1'b1
) (
    input  wire           clk,
    input  wire           rst,
    sseg_spi_ctrl_if.slave bus
);

    localparam int               c_div_w       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int               c_gap_w       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(CLK_DIV - 1);
    localparam logic [c_gap_w-1:0] c_gap_last  = c_gap_w'(GAP - 1);
    localparam logic [7:0]       c_decode_mask = DECODE ? 8'((1 << DIGITS) - 1) : 8'h00;
    localparam logic [7:0]       c_scan_limit  = 8'(DIGITS - 1);
    localparam logic [2:0]       c_init_last   = 3'd5;
    localparam logic [2:0]       c_digit_top   = 3'(DIGITS - 1);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_fin;      // refresh complete this cycle

    logic                r_init;     // still inside the power-up sequence
    logic [2:0]          r_idx;      // init step (counts up) or digit (counts down)
    logic [3:0]          r_bit;
    logic [c_div_w-1:0]  r_div;
    logic                r_sclk;
    logic [c_gap_w-1:0]  r_gap;
    logic                r_pend;
    logic                r_done;
    logic [31:0]         r_dat_s;
    logic [7:0]          r_dp_s;

    logic                w_div_end;
    logic                w_frame_end;
    logic                w_gap_end;
    logic                w_last;
    logic [3:0]          w_nib;
    logic [6:0]          w_seg;
    logic [7:0]          w_data;
    logic [15:0]         w_init_frame;
    logic [15:0]         w_frame;

    assign w_div_end   = (r_div == c_div_last);
    assign w_frame_end = r_sclk && w_div_end && (r_bit == 4'd15);
    assign w_gap_end   = (r_gap == c_gap_last);
    assign w_last      = r_init ? (r_idx == c_init_last) : (r_idx == 3'd0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        w_fin  = 1'b0;
        unique case (r_state)
            S_INIT:  w_next = S_SHIFT;
            S_IDLE:  if (bus.upd) w_next = S_LOAD;
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: if (w_frame_end) w_next = S_GAP;
            S_GAP: begin
                if (w_gap_end) begin
                    if (!w_last) begin
                        w_next = S_SHIFT;
                    end else if (r_init) begin
                        // power-up done: first refresh follows without a request
                        w_next = S_LOAD;
                    end else begin
                        w_fin  = 1'b1;
                        // an upd in this very cycle counts as pending too
                        w_next = (r_pend || bus.upd) ? S_LOAD : S_IDLE;
                    end
                end
            end
            default: w_next = S_INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: bit timing, frame index, snapshot, pending request
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init  <= 1'b1;
            r_idx   <= 3'd0;
            r_bit   <= 4'd0;
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_gap   <= '0;
            r_pend  <= 1'b0;
            r_done  <= 1'b0;
            r_dat_s <= 32'd0;
            r_dp_s  <= 8'd0;
        end else begin
            r_done <= w_fin;

            // Requests during power-up are covered by the automatic refresh.
            if (w_next == S_LOAD) begin
                r_pend <= 1'b0;
            end else if (bus.upd && !r_init && (r_state != S_IDLE)) begin
                r_pend <= 1'b1;
            end

            unique case (r_state)
                S_LOAD: begin
                    r_dat_s <= 32'(bus.dat);
                    r_dp_s  <= 8'(bus.dp);
                    r_idx   <= c_digit_top;
                    r_init  <= 1'b0;
                end
                S_SHIFT: begin
                    if (w_div_end) begin
                        r_div  <= '0;
                        r_sclk <= ~r_sclk;
                        // bit advances at the end of its high phase; wraps to 0 after bit 15
                        if (r_sclk) r_bit <= r_bit + 4'd1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_gap <= '0;
                        if (!w_last) r_idx <= r_init ? (r_idx + 3'd1) : (r_idx - 3'd1);
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame contents for the current init step or digit
    // ------------------------------------------------------------------
    always_comb begin
        w_nib = r_dat_s[{r_idx, 2'b00} +: 4];
        w_seg = 7'h00;
        unique case (w_nib)         // segments A..G, A in the MSB
            4'h0: w_seg = 7'h7E;
            4'h1: w_seg = 7'h30;
            4'h2: w_seg = 7'h6D;
            4'h3: w_seg = 7'h79;
            4'h4: w_seg = 7'h33;
            4'h5: w_seg = 7'h5B;
            4'h6: w_seg = 7'h5F;
            4'h7: w_seg = 7'h70;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h7B;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h1F;
            4'hC: w_seg = 7'h4E;
            4'hD: w_seg = 7'h3D;
            4'hE: w_seg = 7'h4F;
            4'hF: w_seg = 7'h47;
            default: w_seg = 7'h00;
        endcase

        w_data = DECODE ? {r_dp_s[r_idx], 3'b000, w_nib} : {r_dp_s[r_idx], w_seg};

        w_init_frame = 16'h0C00;
        unique case (r_idx)
            3'd0:    w_init_frame = 16'h0C00;                    // shutdown
            3'd1:    w_init_frame = {8'h09, c_decode_mask};      // decode mode
            3'd2:    w_init_frame = {8'h0A, 4'h0, INTENSITY};    // intensity
            3'd3:    w_init_frame = {8'h0B, c_scan_limit};       // scan limit
            3'd4:    w_init_frame = 16'h0F00;                    // display test off
            3'd5:    w_init_frame = 16'h0C01;                    // normal operation
            default: w_init_frame = 16'h0C00;
        endcase

        w_frame = r_init ? w_init_frame : {4'h0, {1'b0, r_idx} + 4'd1, w_data};
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registers only)
    // ------------------------------------------------------------------
    assign bus.cs_n = (r_state != S_SHIFT);
    assign bus.sclk = r_sclk;
    assign bus.sdo  = (r_state == S_SHIFT) && w_frame[4'd15 - r_bit];
    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sseg_spi_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_spi_ctrl
//  Purpose  : Self-checking bench for sseg_spi_ctrl. Two instances (decode
//             mode with 8 digits, raw-segment mode with 2 digits) are driven
//             with random display values; expected SPI frames and done
//             pulses are queued per instance and checked by an SPI monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_spi_ctrl;

    localparam int         D0 = 8, CD0 = 2, G0 = 2;
    localparam int         D1 = 2, CD1 = 1, G1 = 1;
    localparam logic [3:0] I0 = 4'h8, I1 = 4'h3;

    logic clk = 1'b0;
    logic rst0, rst1;
    logic rs0 = 1'b1, rs1 = 1'b1;    // reset as seen by the DUT at the last edge

    always #5 clk = ~clk;
    always @(posedge clk) begin
        rs0 <= rst0;
        rs1 <= rst1;
    end

    sseg_spi_ctrl_if #(.DIGITS(D0)) b0 ();
    sseg_spi_ctrl_if #(.DIGITS(D1)) b1 ();

    sseg_spi_ctrl #(.DIGITS(D0), .CLK_DIV(CD0), .GAP(G0), .INTENSITY(I0), .DECODE(1'b1)) u_dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (b0)
    );

    sseg_spi_ctrl #(.DIGITS(D1), .CLK_DIV(CD1), .GAP(G1), .INTENSITY(I1), .DECODE(1'b0)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (b1)
    );

    // ---------------------------------------------------------------- model
    typedef struct {
        logic        mark;   // 1 = done pulse expected, 0 = SPI frame
        logic        busy;   // busy expected together with done
        int          gap;    // cs_n-high cycles before this frame (0 = unchecked)
        logic [15:0] fr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_vec = 0;
    int n_err = 0;
    int exp_done[2] = '{0, 0};

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    function automatic int digits_of(input int id);
        return (id == 0) ? D0 : D1;
    endfunction

    function automatic int gap_of(input int id);
        return (id == 0) ? G0 : G1;
    endfunction

    function automatic logic [15:0] ref_init(input int id, input int step);
        int  d   = digits_of(id);
        bit  dec = (id == 0);
        int  val;
        case (step)
            0:       val = 'h0C00;
            1:       val = 'h0900 + (dec ? ((1 << d) - 1) : 0);
            2:       val = 'h0A00 + ((id == 0) ? int'(I0) : int'(I1));
            3:       val = 'h0B00 + (d - 1);
            4:       val = 'h0F00;
            default: val = 'h0C01;
        endcase
        return 16'(val);
    endfunction

    task automatic push(input int id, input exp_t e);
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    task automatic push_init(input int id);
        exp_t e;
        for (int s = 0; s < 6; s++) begin
            e.mark = 1'b0; e.busy = 1'b0;
            e.gap  = (s == 0) ? 0 : gap_of(id);
            e.fr   = ref_init(id, s);
            push(id, e);
        end
    endtask

    // One refresh: digits from highest to lowest, then the done pulse.
    task automatic push_refresh(input int id, input logic [31:0] dat, input logic [7:0] dp,
                                input int first_gap);
        exp_t e;
        int   d = digits_of(id);
        int   nib, data;
        for (int i = d - 1; i >= 0; i--) begin
            nib  = int'((dat >> (4 * i)) & 32'hF);
            data = (id == 0) ? nib : int'(seg_tab[nib]);
            if (dp[i]) data += 128;
            e.mark = 1'b0; e.busy = 1'b0;
            e.gap  = (i == d - 1) ? first_gap : gap_of(id);
            e.fr   = 16'((i + 1) * 256 + data);
            push(id, e);
        end
        e.mark = 1'b1; e.busy = 1'b0; e.gap = 0; e.fr = 16'h0;
        push(id, e);
        exp_done[id]++;
    endtask

    // The queued refresh will be followed directly by another one.
    task automatic mark_pending(input int id);
        exp_t e;
        if (id == 0) begin e = q0.pop_back(); e.busy = 1'b1; q0.push_back(e); end
        else         begin e = q1.pop_back(); e.busy = 1'b1; q1.push_back(e); end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // -------------------------------------------------------------- monitor
    int          fr_cnt[2], done_cnt[2], nbits[2], lowc[2], highc[2], gapm[2];
    logic [15:0] sh[2];
    logic        prv_sclk[2], prv_csn[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            fr_cnt[i] = 0; done_cnt[i] = 0; nbits[i] = 0; lowc[i] = 0;
            highc[i] = 0; gapm[i] = 0; sh[i] = 16'h0; prv_sclk[i] = 1'b0; prv_csn[i] = 1'b1;
        end
    end

    task automatic pop(input int id, output exp_t e);
        e.mark = 1'bx; e.busy = 1'bx; e.gap = -1; e.fr = 16'hxxxx;
        if (id == 0 && q0.size() > 0) e = q0.pop_front();
        if (id == 1 && q1.size() > 0) e = q1.pop_front();
    endtask

    task automatic mon(input int id, input logic r, input logic cs_n, input logic sclk,
                       input logic sdo, input logic done, input logic busy);
        exp_t e;
        int   cd = (id == 0) ? CD0 : CD1;
        if (r) begin
            chk($sformatf("d%0d_reset_outputs{cs_n,sclk,sdo,done,busy}", id),
                {cs_n, sclk, sdo, done, busy}, 5'b10001);
            nbits[id] = 0; lowc[id] = 0; highc[id] = 0; fr_cnt[id] = 0;
            prv_sclk[id] = 1'b0; prv_csn[id] = 1'b1;
            return;
        end
        if (!cs_n) begin
            if (prv_csn[id]) begin
                gapm[id] = highc[id]; lowc[id] = 0; nbits[id] = 0; sh[id] = 16'h0;
            end
            lowc[id]++;
            if (sclk && !prv_sclk[id]) begin
                sh[id] = {sh[id][14:0], sdo};
                nbits[id]++;
            end
        end else begin
            if (!prv_csn[id]) begin
                pop(id, e);
                chk($sformatf("d%0d_frame#%0d", id, fr_cnt[id]), {1'b0, sh[id]}, {e.mark, e.fr});
                chk($sformatf("d%0d_bits#%0d", id, fr_cnt[id]), nbits[id], 16);
                chk($sformatf("d%0d_cs_low_cycles#%0d", id, fr_cnt[id]), lowc[id], 32 * cd);
                chk($sformatf("d%0d_idle_lines{sclk,sdo}", id), {sclk, sdo}, 2'b00);
                if (e.gap > 0)
                    chk($sformatf("d%0d_cs_high_cycles#%0d", id, fr_cnt[id]), gapm[id], e.gap);
                fr_cnt[id]++;
                highc[id] = 0;
            end
            highc[id]++;
        end
        if (done) begin
            pop(id, e);
            chk($sformatf("d%0d_done{mark,busy}", id), {1'b1, busy}, {e.mark, e.busy});
            done_cnt[id]++;
        end
        prv_sclk[id] = sclk;
        prv_csn[id]  = cs_n;
    endtask

    always @(negedge clk) begin
        mon(0, rs0, b0.cs_n, b0.sclk, b0.sdo, b0.done, b0.busy);
        mon(1, rs1, b1.cs_n, b1.sclk, b1.sdo, b1.done, b1.busy);
    end

    // ------------------------------------------------------------- stimulus
    logic [31:0] d0;
    logic [7:0]  p0;
    logic [7:0]  d1;
    logic [1:0]  p1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_new;
        d0 = $urandom; p0 = 8'($urandom); d1 = 8'($urandom); p1 = 2'($urandom);
        b0.dat = d0; b0.dp = p0; b1.dat = d1; b1.dp = p1;
    endtask

    task automatic pulse_both;
        b0.upd = 1'b1; b1.upd = 1'b1;
        tick(1);
        b0.upd = 1'b0; b1.upd = 1'b0;
    endtask

    task automatic wait_done(input int id, input int budget);
        int k = 0;
        while (done_cnt[id] < exp_done[id] && k < budget) begin
            tick(1);
            k++;
        end
        if (done_cnt[id] < exp_done[id])
            chk($sformatf("d%0d_done_timeout", id), done_cnt[id], exp_done[id]);
    endtask

    initial begin
        int k;
        rst0 = 1'b1; rst1 = 1'b1;
        b0.upd = 1'b0; b1.upd = 1'b0;
        drive_new();
        tick(3);
        push_init(0); push_refresh(0, d0, p0, G0 + 1);
        push_init(1); push_refresh(1, 32'(d1), 8'(p1), G1 + 1);
        rst0 = 1'b0; rst1 = 1'b0;

        // requests during power-up are absorbed by the automatic refresh
        tick(20);
        pulse_both();

        // reset DUT0 at bit 7 of init frame 3; the whole sequence restarts
        k = 0;
        while (!(fr_cnt[0] == 3 && nbits[0] == 7) && k < 2000) begin tick(1); k++; end
        if (k >= 2000) chk("d0_wait_frame3_bit7", fr_cnt[0], 3);
        q0.delete();
        exp_done[0] = 0;
        rst0 = 1'b1;
        tick(2);
        rst0 = 1'b0;
        push_init(0); push_refresh(0, d0, p0, G0 + 1);
        wait_done(0, 3000);
        wait_done(1, 3000);

        // fixed patterns
        d0 = 32'h1234_5678; p0 = 8'h01; d1 = 8'hF0; p1 = 2'b00;
        b0.dat = d0; b0.dp = p0; b1.dat = d1; b1.dp = p1;
        push_refresh(0, d0, p0, 0); push_refresh(1, 32'(d1), 8'(p1), 0);
        pulse_both();
        wait_done(0, 1000); wait_done(1, 1000);

        // random refreshes; inputs change mid-refresh and must not leak in
        for (int n = 0; n < 4; n++) begin
            tick(3);
            drive_new();
            push_refresh(0, d0, p0, 0); push_refresh(1, 32'(d1), 8'(p1), 0);
            pulse_both();
            tick(12);
            b0.dat = $urandom; b0.dp = 8'($urandom); b1.dat = 8'($urandom); b1.dp = 2'($urandom);
            wait_done(0, 1000); wait_done(1, 1000);
        end

        // three requests during a refresh collapse into one more refresh
        tick(3);
        drive_new();
        push_refresh(0, d0, p0, 0); push_refresh(1, 32'(d1), 8'(p1), 0);
        pulse_both();
        tick(10);
        for (int n = 0; n < 3; n++) begin
            drive_new();
            pulse_both();
            tick(4);
        end
        mark_pending(0); mark_pending(1);
        push_refresh(0, d0, p0, G0 + 1); push_refresh(1, 32'(d1), 8'(p1), G1 + 1);
        wait_done(0, 2000); wait_done(1, 2000);

        tick(300);
        chk("d0_scoreboard_left", q0.size(), 0);
        chk("d1_scoreboard_left", q1.size(), 0);
        chk("d0_done_count", done_cnt[0], exp_done[0]);
        chk("d1_done_count", done_cnt[1], exp_done[1]);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
